// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues in-order instruction-memory requests under a credit
// limit, and queues returned words with their PC for decode. Redirects flush the queue.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, rsp_pc_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, outst_q, stale_q;
  logic [CW-1:0] count_d, outst_d, stale_d;
  logic [31:0]   hold_inst_q, hold_pc_q;
  logic [31:0]   redirect_aligned;
  logic          credit, req_fire, rsp_stale, push, pop;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign imem_req_addr    = pc_q;
  assign if_valid         = (count_q != '0);
  assign if_inst          = if_valid ? inst_mem[rd_ptr_q] : hold_inst_q;
  assign if_pc            = if_valid ? pc_mem[rd_ptr_q]   : hold_pc_q;

  // Queued entries plus in-flight requests never exceed DEPTH, so a push always has room.
  assign credit = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      FETCH:   imem_req_valid = credit && !reset;
      FLUSH:   imem_req_valid = 1'b0;
      default: imem_req_valid = 1'b0;
    endcase

    req_fire  = imem_req_valid && imem_req_ready;
    rsp_stale = (stale_q != '0) || redirect_valid;
    push      = imem_rsp_valid && !rsp_stale;
    pop       = if_valid && if_ready;

    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    count_d = count_q + CW'(push) - CW'(pop);
    stale_d = stale_q - CW'(imem_rsp_valid && (stale_q != '0));

    if (redirect_valid) begin
      // Everything still in flight, including this cycle's request, belongs to the old path.
      stale_d = outst_d;
      count_d = '0;
      state_d = (outst_d != '0) ? FLUSH : FETCH;
    end else if ((state_q == FLUSH) && (stale_d == '0)) begin
      state_d = FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      stale_q     <= '0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
      if (if_valid) begin
        hold_inst_q <= inst_mem[rd_ptr_q];
        hold_pc_q   <= pc_mem[rd_ptr_q];
      end
      if (redirect_valid) begin
        pc_q     <= redirect_aligned;
        rsp_pc_q <= redirect_aligned;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // NOTE: the storage array is not reset; occupancy gates every read, so its contents never matter when empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      inst_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
